// File: rtl/huff_node_sorter.sv
// rtl/huff_node_sorter.sv - batch sorter for Huffman nodes using odd-even transposition.
// Nodes load into a register array, sort for DEPTH phases, then stream out smallest-key first.
module huff_node_sorter #(
  parameter int NODE_W  = 8,
  parameter int KEY_W   = 4,
  parameter int DEPTH   = 8,
  parameter int DESCEND = 0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NODE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NODE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PH_W  = $clog2(DEPTH);
  localparam logic [NODE_W-1:0] ONES = '1;
  // Pads carry the extreme key so stable sorting parks them behind every real node.
  localparam logic [NODE_W-1:0] PAD = (DESCEND != 0) ? '0 : ~(ONES >> KEY_W);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [NODE_W-1:0] mem_q [DEPTH];
  logic [NODE_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              sorted_q, sorted_d;
  logic              in_fire, out_fire, close_batch;

  function automatic logic out_of_order(input logic [NODE_W-1:0] a, input logic [NODE_W-1:0] b);
    logic [KEY_W-1:0] ka, kb;
    ka = a[NODE_W-1 -: KEY_W];
    kb = b[NODE_W-1 -: KEY_W];
    if (DESCEND != 0) return ka < kb;
    return ka > kb;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_LOAD;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      n_q      <= '0;
      phase_q  <= '0;
      sorted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      n_q      <= n_d;
      phase_q  <= phase_d;
      sorted_q <= sorted_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    in_fire     = in_valid && in_ready;
    out_fire    = out_valid && out_ready;
    close_batch = in_fire && (in_last || (wr_cnt_q == CNT_W'(DEPTH - 1)));
    state_d     = state_q;
    case (state_q)
      S_LOAD:  if (close_batch) state_d = S_SORT;
      S_SORT:  if (sorted_q) state_d = S_OUT;
      S_OUT:   if (out_fire && out_last) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    n_d      = n_q;
    phase_d  = phase_q;
    sorted_d = sorted_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == wr_cnt_q) mem_d[i] = in_data;
            else if (close_batch && (CNT_W'(i) > wr_cnt_q)) mem_d[i] = PAD;
          end
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (close_batch) begin
            n_d      = wr_cnt_q + CNT_W'(1);
            phase_d  = '0;
            sorted_d = 1'b0;
          end
        end
      end
      S_SORT: begin
        if (sorted_q) begin
          rd_ptr_d = '0;
        end else begin
          // Pairs in one phase are disjoint, so every swap reads only registered values.
          for (int i = 0; i < DEPTH - 1; i++) begin
            if ((((i % 2) != 0) == phase_q[0]) && out_of_order(mem_q[i], mem_q[i+1])) begin
              mem_d[i]   = mem_q[i+1];
              mem_d[i+1] = mem_q[i];
            end
          end
          phase_d = phase_q + PH_W'(1);
          if (phase_q == PH_W'(DEPTH - 1)) sorted_d = 1'b1;
        end
      end
      S_OUT: begin
        if (out_fire) begin
          rd_ptr_d = rd_ptr_q + CNT_W'(1);
          if (out_last) wr_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    busy      = (state_q != S_LOAD);
    out_valid = (state_q == S_OUT);
    out_last  = (state_q == S_OUT) && (rd_ptr_q == n_q - CNT_W'(1));
    out_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((state_q == S_OUT) && (CNT_W'(i) == rd_ptr_q)) out_data = mem_q[i];
    end
  end

endmodule

// File: tb/tb_huff_node_sorter.sv
// tb/tb_huff_node_sorter.sv - randomized and directed bench for huff_node_sorter.
// Instance 0 sorts ascending, instance 1 descending; a queue model checks every output beat.
module tb_huff_node_sorter;

  localparam int NODE_W = 8;
  localparam int KEY_W  = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid_w  [2];
  logic              in_ready_w  [2];
  logic [NODE_W-1:0] in_data_w   [2];
  logic              in_last_w   [2];
  logic              out_valid_w [2];
  logic              out_ready_w [2];
  logic [NODE_W-1:0] out_data_w  [2];
  logic              out_last_w  [2];
  logic              busy_w      [2];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [NODE_W-1:0] exp_q [2][$];
  bit                mload [2];
  int                mcnt  [2];

  always #5 clk = ~clk;

  huff_node_sorter #(.NODE_W(NODE_W), .KEY_W(KEY_W), .DEPTH(DEPTH), .DESCEND(0)) dut_asc (
    .CLK(clk), .nRST(rst_n),
    .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]), .in_data(in_data_w[0]), .in_last(in_last_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_w[0]), .out_data(out_data_w[0]),
    .out_last(out_last_w[0]), .busy(busy_w[0])
  );

  huff_node_sorter #(.NODE_W(NODE_W), .KEY_W(KEY_W), .DEPTH(DEPTH), .DESCEND(1)) dut_desc (
    .CLK(clk), .nRST(rst_n),
    .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]), .in_data(in_data_w[1]), .in_last(in_last_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_w[1]), .out_data(out_data_w[1]),
    .out_last(out_last_w[1]), .busy(busy_w[1])
  );

  task automatic chk(input bit ok, input string name, input int act, input int exp_v);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  function automatic int key_of(input logic [NODE_W-1:0] node);
    return int'(node[NODE_W-1 -: KEY_W]);
  endfunction

  // Stable insertion: a new node goes after every node whose key does not beat it.
  task automatic model_sort(input logic [NODE_W-1:0] src[$], input bit desc,
                            output logic [NODE_W-1:0] dst[$]);
    dst.delete();
    foreach (src[k]) begin
      int pos;
      pos = dst.size();
      for (int j = 0; j < dst.size(); j++) begin
        if (desc ? (key_of(dst[j]) < key_of(src[k])) : (key_of(dst[j]) > key_of(src[k]))) begin
          pos = j;
          break;
        end
      end
      dst.insert(pos, src[k]);
    end
  endtask

  task automatic pin_model(input logic [NODE_W-1:0] src[$], input bit desc,
                           input logic [NODE_W-1:0] want[$], input string name);
    logic [NODE_W-1:0] got[$];
    bit ok;
    int first_bad;
    model_sort(src, desc, got);
    ok = (got.size() == want.size());
    first_bad = -1;
    if (ok) begin
      foreach (want[k]) if (got[k] != want[k] && first_bad < 0) first_bad = k;
      ok = (first_bad < 0);
    end
    chk(ok, name, (first_bad < 0) ? got.size() : int'(got[first_bad]),
        (first_bad < 0) ? want.size() : int'(want[first_bad]));
  endtask

  // Cycle-level reference: in_ready/busy follow the batch life cycle, outputs pop the sorted queue.
  initial begin
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (!rst_n) begin
          mload[s] = 1'b1;
          mcnt[s]  = 0;
          exp_q[s].delete();
        end else begin
          chk((in_ready_w[s] == mload[s]) && (busy_w[s] == !mload[s]), "in_ready_busy",
              int'({in_ready_w[s], busy_w[s]}), int'({mload[s], !mload[s]}));
          if (mload[s] && in_valid_w[s]) begin
            mcnt[s]++;
            if (in_last_w[s] || mcnt[s] == DEPTH) begin
              mload[s] = 1'b0;
              mcnt[s]  = 0;
            end
          end
          if (out_valid_w[s]) begin
            if (exp_q[s].size() == 0) begin
              chk(1'b0, "unexpected_out", int'(out_data_w[s]), 0);
            end else begin
              chk((out_data_w[s] == exp_q[s][0]) && (out_last_w[s] == (exp_q[s].size() == 1)),
                  "out_node", int'({out_last_w[s], out_data_w[s]}),
                  int'({exp_q[s].size() == 1, exp_q[s][0]}));
              if (out_ready_w[s]) begin
                void'(exp_q[s].pop_front());
                if (exp_q[s].size() == 0) mload[s] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  task automatic send_beat(input int s, input logic [NODE_W-1:0] d, input bit last, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    in_valid_w[s] = 1'b1;
    in_data_w[s]  = d;
    in_last_w[s]  = last;
    while (!done && waited < 100) begin
      @(negedge clk);
      if (in_ready_w[s]) done = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    if (!done) chk(1'b0, "send_timeout", waited, 0);
  endtask

  task automatic send_batch(input int s, input logic [NODE_W-1:0] nodes[$], input bit use_last);
    logic [NODE_W-1:0] sorted[$];
    int w;
    model_sort(nodes, bit'(s), sorted);
    foreach (sorted[k]) exp_q[s].push_back(sorted[k]);
    foreach (nodes[k]) send_beat(s, nodes[k], use_last && (k == nodes.size() - 1), w);
  endtask

  task automatic wait_first_valid(input int s);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_valid_w[s]) seen = 1'b1;
    end
    chk(seen && (k == DEPTH + 1), "latency", k, DEPTH + 1);
  endtask

  // mode 0: always ready; 1: five stalled cycles then alternate; 2: random
  task automatic drain(input int s, input int mode, input int n_exp);
    int hs, cyc;
    bit done, prev_stall;
    logic [NODE_W-1:0] prev_data;
    hs = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready_w[s] = 1'b1;
        1:       out_ready_w[s] = (cyc < 5) ? 1'b0 : ((cyc % 2) == 1);
        default: out_ready_w[s] = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      @(negedge clk);
      if (prev_stall)
        chk(out_valid_w[s] && (out_data_w[s] == prev_data), "stall_hold", int'(out_data_w[s]), int'(prev_data));
      prev_stall = out_valid_w[s] && !out_ready_w[s];
      prev_data  = out_data_w[s];
      if (out_valid_w[s] && out_ready_w[s]) begin
        hs++;
        if (out_last_w[s]) done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    out_ready_w[s] = 1'b0;
    chk(done && (hs == n_exp), "handshakes", hs, n_exp);
  endtask

  task automatic run_batch(input int s, input logic [NODE_W-1:0] nodes[$], input bit use_last,
                           input int mode, input bit check_lat);
    send_batch(s, nodes, use_last);
    in_valid_w[s] = 1'b0;
    in_last_w[s]  = 1'b0;
    if (check_lat) wait_first_valid(s);
    drain(s, mode, nodes.size());
  endtask

  logic [NODE_W-1:0] full_b[$], part_b[$], desc_b[$], rst_b[$], want[$], rnd_b[$], b2[$];

  initial begin
    int w, k;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid_w[s] = 1'b0; in_data_w[s] = '0; in_last_w[s] = 1'b0; out_ready_w[s] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk(in_ready_w[s] == 1'b1, "reset_in_ready", int'(in_ready_w[s]), 1);
      chk(!out_valid_w[s] && !out_last_w[s] && !busy_w[s] && (out_data_w[s] == '0), "reset_outputs",
          int'({out_valid_w[s], out_last_w[s], busy_w[s], out_data_w[s]}), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    full_b = '{8'h31, 8'h12, 8'h73, 8'h14, 8'h55, 8'h06, 8'h27, 8'h48};
    part_b = '{8'hF1, 8'h22, 8'hF0};
    desc_b = '{8'h10, 8'h30, 8'h20, 8'h31};
    rst_b  = '{8'h50, 8'h41};
    want = '{8'h06, 8'h12, 8'h14, 8'h27, 8'h31, 8'h48, 8'h55, 8'h73};
    pin_model(full_b, 1'b0, want, "model_full");
    want = '{8'h22, 8'hF1, 8'hF0};
    pin_model(part_b, 1'b0, want, "model_ties");
    want = '{8'h30, 8'h31, 8'h20, 8'h10};
    pin_model(desc_b, 1'b1, want, "model_desc");
    want = '{8'h41, 8'h50};
    pin_model(rst_b, 1'b0, want, "model_pair");

    run_batch(0, full_b, 1'b0, 0, 1'b1);
    run_batch(0, part_b, 1'b1, 0, 1'b1);
    run_batch(0, full_b, 1'b0, 1, 1'b1);

    send_batch(0, full_b, 1'b0);
    in_valid_w[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk(!out_valid_w[0] && in_ready_w[0] && !busy_w[0], "reset_mid_sort",
        int'({out_valid_w[0], in_ready_w[0], busy_w[0]}), 3'b010);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_batch(0, rst_b, 1'b1, 0, 1'b1);

    run_batch(1, desc_b, 1'b1, 0, 1'b1);

    send_batch(0, full_b, 1'b0);
    out_ready_w[0] = 1'b1;
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      #1;
      if (in_ready_w[0]) break;
      in_data_w[0] = 8'($urandom);
      in_last_w[0] = 1'($urandom);
      k++;
    end
    chk(k < 100, "b2b_return", k, 0);
    b2 = '{8'h9A, 8'h3B, 8'h9C};
    model_sort(b2, 1'b0, want);
    foreach (want[j]) exp_q[0].push_back(want[j]);
    send_beat(0, b2[0], 1'b0, w);
    chk(w == 0, "b2b_first_accept", w, 0);
    send_beat(0, b2[1], 1'b0, w);
    send_beat(0, b2[2], 1'b1, w);
    in_valid_w[0] = 1'b0;
    in_last_w[0]  = 1'b0;
    drain(0, 0, 3);

    for (int r = 0; r < 24; r++) begin
      int s, len;
      bit ul;
      s   = $urandom_range(0, 1);
      len = $urandom_range(1, DEPTH);
      rnd_b.delete();
      for (int j = 0; j < len; j++) rnd_b.push_back(8'($urandom));
      ul = (len < DEPTH) ? 1'b1 : 1'($urandom);
      run_batch(s, rnd_b, ul, (r % 3 == 0) ? 0 : 2, (r % 4) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk(exp_q[0].size() == 0 && exp_q[1].size() == 0, "queues_empty",
        exp_q[0].size() + exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/huff_node_sorter.md
Name: huff_node_sorter

Overview:
- Sequential N-entry sorter for Huffman tree nodes. It is the parametrised successor of the two-node compare/swap stage.
- Nodes are streamed in with a valid/ready handshake. They are sorted by a key field using odd-even transposition over an internal register array, then streamed out in sorted order.
- Sits between the frequency counter and the tree-merge stage. The tree-merge stage consumes the two smallest nodes first.

Parameters:
- NODE_W, 8: node width in bits.
- KEY_W, 4: key (frequency) width. Key is node[NODE_W-1 -: KEY_W]. Requires KEY_W <= NODE_W.
- DEPTH, 8: maximum nodes per batch. Requires DEPTH >= 2.
- DESCEND, 0: 0 = ascending key order; 1 = descending key order.

Ports:
- CLK, input, 1: clock, rising edge.
- nRST, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: input node valid.
- in_ready, output, 1: sorter accepts input.
- in_data, input, NODE_W: input node.
- in_last, input, 1: marks the final node of the batch when fewer than DEPTH nodes are sent.
- out_valid, output, 1: sorted node valid.
- out_ready, input, 1: downstream accepts the node.
- out_data, output, NODE_W: sorted node.
- out_last, output, 1: marks the last real node of the batch.
- busy, output, 1: high in SORT and OUT states.

Behaviour:
- Interface: one clock CLK. Reset nRST is asynchronous and active-low.
- Reset values:
  - State = LOAD; all array entries = 0; wr_cnt = 0; rd_ptr = 0; n = 0; phase = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_data = 0.
- Reset mid-operation: asserting nRST in any state discards the batch immediately. No partial output follows.
- Handshake: a beat transfers on a rising edge where valid && ready.

LOAD state:
- in_ready = 1.
- Each accepted beat writes mem[wr_cnt] and increments wr_cnt.
- The batch closes when the accepted beat has in_last = 1, or when wr_cnt reaches DEPTH-1 on acceptance. In the second case in_last is ignored.
- On close:
  - n = number of accepted nodes (1..DEPTH).
  - mem[n..DEPTH-1] are filled with the pad node: key all ones (DESCEND = 0) or all zeros (DESCEND = 1), low bits 0.
  - State goes to SORT, phase = 0, and in_ready drops on the same edge.

SORT state:
- in_ready = 0, out_valid = 0.
- Each edge performs one phase on all pairs in parallel:
  - Even phase compares pairs (0,1), (2,3), ...
  - Odd phase compares pairs (1,2), (3,4), ...
- A pair (i, i+1) swaps only if key[i] > key[i+1] (DESCEND = 0) or key[i] < key[i+1] (DESCEND = 1).
- Equal keys never swap. The sort is therefore stable: equal-key nodes, including pads after real nodes, keep arrival order.
- After exactly DEPTH phases, state goes to OUT with rd_ptr = 0.
- Latency: out_valid rises DEPTH+1 edges after the edge that accepted the closing beat. This is fixed and independent of the data.

OUT state:
- out_valid = 1, out_data = mem[rd_ptr], out_last = (rd_ptr == n-1).
- On handshake, rd_ptr increments.
- out_data and out_last stay stable while out_valid && !out_ready.
- On the out_last handshake:
  - State returns to LOAD, wr_cnt = 0, busy = 0.
  - in_ready rises in the following cycle. The next batch may start on the next edge.
- Pad entries are never output.

Input rules:
- in_valid while in_ready = 0 is ignored. Data is not consumed and no error is raised.
- A single-beat batch (in_last on the first beat) gives n = 1. It still sorts for DEPTH cycles and then outputs one node with out_last = 1.

Arithmetic and widths:
- wr_cnt, rd_ptr, n: $clog2(DEPTH+1) bits.
- phase: $clog2(DEPTH) bits.
- Key comparison is unsigned. No arithmetic overflow is possible.

Test Plan:
- Full batch (DEPTH = 8, ascending):
  - Stimulus: 0x31, 0x12, 0x73, 0x14, 0x55, 0x06, 0x27, 0x48 with no in_last.
  - Required output: 0x06, 0x12, 0x14, 0x27, 0x31, 0x48, 0x55, 0x73, with out_last only on 0x73.
  - Required timing: first out_valid exactly 9 edges after the 8th accept.
- Partial batch with ties:
  - Stimulus: 0xF1, 0x22, 0xF0 with in_last on 0xF0.
  - Required output: 0x22, 0xF1, 0xF0 (stable), with out_last on 0xF0.
  - Also required: no pad is output and in_ready stays 0 until after the last handshake.
- Backpressure:
  - Stimulus: the first case with out_ready = 0 for 5 cycles, then toggled 1/0.
  - Required: out_data held stable while stalled; sequence unchanged; exactly 8 handshakes.
- Reset mid-sort:
  - Stimulus: nRST asserted 3 cycles into SORT, then released, then a 2-node batch 0x50, 0x41 (in_last on 0x41).
  - Required: out_valid = 0 and in_ready = 1 immediately on reset; the new batch outputs 0x41, 0x50 only.
- Descending (DESCEND = 1):
  - Stimulus: 0x10, 0x30, 0x20, 0x31 with in_last.
  - Required output: 0x30, 0x31, 0x20, 0x10.
- Back-to-back batches and ignored input:
  - Stimulus: in_valid held high during SORT/OUT with changing data.
  - Required: no capture while in_ready = 0; the second batch is loaded starting the cycle after the first batch's out_last handshake.
